// File: rtl/z80_block_xfer_engine.sv
// z80_block_xfer_engine
//   Runs one LDI/LDD/LDIR/LDDR iteration per start: memory read, memory write,
//   extended cycles and, for a repeating form that has not run out, the repeat
//   cycles. Returns updated HL/DE/BC/F and tells the sequencer whether IP must
//   rewind, so interrupts can be taken between iterations.
//
// Optional feature macro: Z80_BLOCK_XFER_UNDOC_XY_EN
//   Defined   : F bits 3/5 come from n = A + transferred byte (bit3 = n[3], bit5 = n[1]).
//   Undefined : F bits 3/5 are copied from f_in and a_in is unused.
//
// Ports
//   clk, reset               core clock, asynchronous active-high reset
//   start                    begin an iteration (sampled only in IDLE)
//   mode_dec, mode_rep       pointer direction / repeating form
//   hl_in, de_in, bc_in      source, destination, count
//   a_in, f_in               accumulator (optional feature only), flags
//   bus_rd_*                 read handshake (req/addr out, rdata/ack in)
//   bus_wr_*                 write handshake (req/addr/wdata out, ack in)
//   hl_out, de_out, bc_out   updated registers, valid from the done cycle on
//   f_out                    updated flags
//   busy, done, rewind       status; rewind is meaningful with done
module z80_block_xfer_engine #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned REP_CYCLES = 5,
    parameter int unsigned EXT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_dec,
    input  logic              mode_rep,
    input  logic [ADDR_W-1:0] hl_in,
    input  logic [ADDR_W-1:0] de_in,
    input  logic [CNT_W-1:0]  bc_in,
    input  logic [7:0]        a_in,
    input  logic [7:0]        f_in,
    output logic              bus_rd_req,
    output logic [ADDR_W-1:0] bus_raddr,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_rd_ack,
    output logic              bus_wr_req,
    output logic [ADDR_W-1:0] bus_waddr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_wr_ack,
    output logic [ADDR_W-1:0] hl_out,
    output logic [ADDR_W-1:0] de_out,
    output logic [CNT_W-1:0]  bc_out,
    output logic [7:0]        f_out,
    output logic              busy,
    output logic              done,
    output logic              rewind
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRead  = 3'd1;
    localparam logic [2:0] StWrite = 3'd2;
    localparam logic [2:0] StExt   = 3'd3;
    localparam logic [2:0] StRep   = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    // Bus phases never leave before their third cycle.
    localparam logic [7:0] MinBusLast = 8'd2;
    localparam logic [7:0] ExtLast    = 8'(EXT_CYCLES - 1);
    localparam logic [7:0] RepLast    = 8'(REP_CYCLES - 1);

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ack_seen_q, ack_seen_d;
    logic              dec_q, rep_q;
    logic [ADDR_W-1:0] hl_q, de_q;
    logic [CNT_W-1:0]  bc_q;
    logic [7:0]        f_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] hl_out_q, de_out_q;
    logic [CNT_W-1:0]  bc_out_q;
    logic [7:0]        f_out_q;

    logic              rd_ack_v, wr_ack_v;
    logic [7:0]        cnt_inc;
    logic [CNT_W-1:0]  bc_new;
    logic              pv, rep_go, load_out;
    logic [7:0]        f_new;
    logic              xy3, xy5;

    assign bus_rd_req = (state_q == StRead) && !ack_seen_q;
    assign bus_wr_req = (state_q == StWrite) && !ack_seen_q;
    assign bus_raddr  = hl_q;
    assign bus_waddr  = de_q;
    assign bus_wdata  = data_q;

    // An ack only counts while its request is actually up.
    assign rd_ack_v = bus_rd_req && bus_rd_ack;
    assign wr_ack_v = bus_wr_req && bus_wr_ack;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign bc_new  = bc_q - CNT_W'(1);
    assign pv      = (bc_new != '0);
    assign rep_go  = rep_q && pv;

    // Results are committed on the edge that enters DONE.
    assign load_out = ((state_q == StExt) && (cnt_q == ExtLast) && !rep_go) ||
                      ((state_q == StRep) && (cnt_q == RepLast));

`ifdef Z80_BLOCK_XFER_UNDOC_XY_EN
    logic [7:0] a_q;
    logic [7:0] xy_n;
    logic       unused_f;
    assign xy_n     = a_q + 8'(data_q);
    assign xy3      = xy_n[3];
    assign xy5      = xy_n[1];
    assign unused_f = ^{f_q[5], f_q[4], f_q[3], f_q[2], f_q[1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
        end else if (state_q == StIdle && start) begin
            a_q <= a_in;
        end
    end
`else
    logic unused_a;
    logic unused_f;
    assign xy3      = f_q[3];
    assign xy5      = f_q[5];
    assign unused_a = ^a_in;
    assign unused_f = ^{f_q[4], f_q[2], f_q[1]};
`endif

    // S, Z, C kept; H and N cleared; PV reports a non-zero remaining count.
    assign f_new = {f_q[7], f_q[6], xy5, 1'b0, xy3, pv, 1'b0, f_q[0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_seen_d = ack_seen_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRead;
                    cnt_d      = '0;
                    ack_seen_d = 1'b0;
                end
            end
            StRead: begin
                cnt_d = cnt_inc;
                if (rd_ack_v) ack_seen_d = 1'b1;
                if ((ack_seen_q || rd_ack_v) && cnt_q >= MinBusLast) begin
                    state_d    = StWrite;
                    cnt_d      = '0;
                    ack_seen_d = 1'b0;
                end
            end
            StWrite: begin
                cnt_d = cnt_inc;
                if (wr_ack_v) ack_seen_d = 1'b1;
                if ((ack_seen_q || wr_ack_v) && cnt_q >= MinBusLast) begin
                    state_d    = StExt;
                    cnt_d      = '0;
                    ack_seen_d = 1'b0;
                end
            end
            StExt: begin
                cnt_d = cnt_inc;
                if (cnt_q == ExtLast) begin
                    state_d = rep_go ? StRep : StDone;
                    cnt_d   = '0;
                end
            end
            StRep: begin
                cnt_d = cnt_inc;
                if (cnt_q == RepLast) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ack_seen_q <= 1'b0;
            dec_q      <= 1'b0;
            rep_q      <= 1'b0;
            hl_q       <= '0;
            de_q       <= '0;
            bc_q       <= '0;
            f_q        <= '0;
            data_q     <= '0;
            hl_out_q   <= '0;
            de_out_q   <= '0;
            bc_out_q   <= '0;
            f_out_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_seen_q <= ack_seen_d;
            if (state_q == StIdle && start) begin
                dec_q <= mode_dec;
                rep_q <= mode_rep;
                hl_q  <= hl_in;
                de_q  <= de_in;
                bc_q  <= bc_in;
                f_q   <= f_in;
            end
            if (rd_ack_v) data_q <= bus_rdata;
            if (load_out) begin
                hl_out_q <= dec_q ? hl_q - ADDR_W'(1) : hl_q + ADDR_W'(1);
                de_out_q <= dec_q ? de_q - ADDR_W'(1) : de_q + ADDR_W'(1);
                bc_out_q <= bc_new;
                f_out_q  <= f_new;
            end
        end
    end

    assign hl_out = hl_out_q;
    assign de_out = de_out_q;
    assign bc_out = bc_out_q;
    assign f_out  = f_out_q;
    assign done   = (state_q == StDone);
    assign busy   = (state_q != StIdle) && (state_q != StDone);
    assign rewind = (state_q == StDone) && rep_go;

endmodule

// File: tb/tb_z80_block_xfer_engine.sv
module tb_z80_block_xfer_engine;

    localparam int AW  = 16;
    localparam int CW  = 16;
    localparam int DW  = 8;
    localparam int REP = 5;
    localparam int EXT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, mode_dec, mode_rep;
    logic [AW-1:0] hl_in, de_in;
    logic [CW-1:0] bc_in;
    logic [7:0]    a_in, f_in;
    logic          bus_rd_req, bus_rd_ack, bus_wr_req, bus_wr_ack;
    logic [AW-1:0] bus_raddr, bus_waddr;
    logic [DW-1:0] bus_rdata, bus_wdata;
    logic [AW-1:0] hl_out, de_out;
    logic [CW-1:0] bc_out;
    logic [7:0]    f_out;
    logic          busy, done, rewind;

    z80_block_xfer_engine #(
        .ADDR_W(AW), .CNT_W(CW), .DATA_W(DW), .REP_CYCLES(REP), .EXT_CYCLES(EXT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode_dec(mode_dec), .mode_rep(mode_rep),
        .hl_in(hl_in), .de_in(de_in), .bc_in(bc_in), .a_in(a_in), .f_in(f_in),
        .bus_rd_req(bus_rd_req), .bus_raddr(bus_raddr), .bus_rdata(bus_rdata),
        .bus_rd_ack(bus_rd_ack), .bus_wr_req(bus_wr_req), .bus_waddr(bus_waddr),
        .bus_wdata(bus_wdata), .bus_wr_ack(bus_wr_ack), .hl_out(hl_out), .de_out(de_out),
        .bc_out(bc_out), .f_out(f_out), .busy(busy), .done(done), .rewind(rewind)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after rd_wait/wr_wait extra cycles of request, and
    // throws in random acks while no request is up (these must be ignored).
    int          rd_wait = 0, wr_wait = 0, rd_w = 0, wr_w = 0, rd_acks = 0, wr_acks = 0;
    logic [7:0]  rd_byte = '0;
    logic [AW-1:0] seen_raddr = '0, seen_waddr = '0;
    logic [7:0]  seen_wdata = '0;

    always @(negedge clk) begin
        if (reset) begin
            rd_w = 0; wr_w = 0; bus_rd_ack = 1'b0; bus_wr_ack = 1'b0; bus_rdata = '0;
        end else begin
            if (bus_rd_req) begin
                rd_w++;
                if (rd_w > rd_wait) begin
                    bus_rd_ack = 1'b1; bus_rdata = rd_byte; seen_raddr = bus_raddr; rd_acks++;
                end else begin
                    bus_rd_ack = 1'b0; bus_rdata = 8'($urandom);
                end
            end else begin
                rd_w = 0; bus_rd_ack = ($urandom_range(0, 3) == 0); bus_rdata = 8'($urandom);
            end
            if (bus_wr_req) begin
                wr_w++;
                if (wr_w > wr_wait) begin
                    bus_wr_ack = 1'b1; seen_waddr = bus_waddr; seen_wdata = bus_wdata; wr_acks++;
                end else begin
                    bus_wr_ack = 1'b0;
                end
            end else begin
                wr_w = 0; bus_wr_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    function automatic int extra(input int w);
        return (w > 2) ? w - 2 : 0;
    endfunction

    task automatic run_xfer(input bit dec, input bit rep, input logic [15:0] hl,
                            input logic [15:0] de, input logic [15:0] bc, input logic [7:0] a,
                            input logic [7:0] f, input logic [7:0] byte_v, input int rw,
                            input int ww, input bit hold);
        logic [15:0] e_hl, e_de, e_bc;
        logic [7:0]  e_f, n;
        bit          e_pv, e_rew;
        int          e_lat, k;
        bit          got;
        e_hl  = dec ? hl - 16'd1 : hl + 16'd1;
        e_de  = dec ? de - 16'd1 : de + 16'd1;
        e_bc  = bc - 16'd1;
        e_pv  = (e_bc != 0);
        e_rew = rep && e_pv;
        n     = a + byte_v;
`ifdef Z80_BLOCK_XFER_UNDOC_XY_EN
        e_f = (f & 8'hC1) | (e_pv ? 8'h04 : 8'h00) | (n & 8'h08) | ((n & 8'h02) << 4);
`else
        e_f = (f & 8'hC1) | (e_pv ? 8'h04 : 8'h00) | (f & 8'h28);
`endif
        e_lat = 9 + extra(rw) + extra(ww) + (e_rew ? REP : 0);

        @(negedge clk);
        mode_dec = dec; mode_rep = rep; hl_in = hl; de_in = de; bc_in = bc; a_in = a; f_in = f;
        rd_byte = byte_v; rd_wait = rw; wr_wait = ww; rd_acks = 0; wr_acks = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        // Inputs must have been latched; scramble them for the rest of the iteration.
        start = hold; mode_dec = ~dec; mode_rep = ~rep;
        hl_in = 16'($urandom); de_in = 16'($urandom); bc_in = 16'($urandom);
        a_in = 8'($urandom); f_in = 8'($urandom);
        k = 0; got = 0;
        while (k < 200 && !got) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) check_eq("busy_after_start", busy, 1'b1);
            if (done) got = 1;
        end
        check_eq("done_seen", got, 1'b1);
        if (got) begin
            check_eq("latency", k + 1, e_lat);
            check_eq("busy_in_done", busy, 1'b0);
            check_eq("hl_out", hl_out, e_hl);
            check_eq("de_out", de_out, e_de);
            check_eq("bc_out", bc_out, e_bc);
            check_eq("f_out", f_out, e_f);
            check_eq("rewind", rewind, e_rew);
            check_eq("raddr", seen_raddr, hl);
            check_eq("waddr", seen_waddr, de);
            check_eq("wdata", seen_wdata, byte_v);
            check_eq("acks", {rd_acks[15:0], wr_acks[15:0]}, 32'h0001_0001);
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            #1;
            check_eq("idle_after_done", {busy, done}, 2'b00);
            check_eq("hl_hold", hl_out, e_hl);
        end
    endtask

    task automatic reset_mid_write();
        int k;
        @(negedge clk);
        mode_dec = 1'b0; mode_rep = 1'b1; hl_in = 16'h4000; de_in = 16'h5000; bc_in = 16'd9;
        a_in = 8'h00; f_in = 8'hC1; rd_byte = 8'h77; rd_wait = 0; wr_wait = 30; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (k < 50 && !bus_wr_req) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("reached_write", bus_wr_req, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_wr_req_drop", bus_wr_req, 1'b0);
        check_eq("rst_status", {busy, done, rewind, bus_rd_req}, 4'b0000);
        check_eq("rst_hl_de", {hl_out, de_out}, 32'h0);
        check_eq("rst_bc_f", {bc_out, f_out}, 24'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_no_done", done, 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_no_done", done, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode_dec = 1'b0; mode_rep = 1'b0;
        hl_in = '0; de_in = '0; bc_in = '0; a_in = '0; f_in = '0;
        bus_rd_ack = 1'b0; bus_wr_ack = 1'b0; bus_rdata = '0;
        #1;
        check_eq("reset_status", {busy, done, rewind, bus_rd_req, bus_wr_req}, 5'b00000);
        check_eq("reset_regs", {hl_out, de_out}, 32'h0);
        check_eq("reset_bc_f", {bc_out, f_out}, 24'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // LDD zero wait
        run_xfer(1'b1, 1'b0, 16'h1000, 16'h2000, 16'd3, 8'h00, 8'hFF, 8'h5A, 0, 0, 1'b0);
        // LDIR with pointer wrap, count runs out
        run_xfer(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'd1, 8'h00, 8'h00, 8'h3C, 0, 0, 1'b0);
        // LDDR with BC=0 wrap
        run_xfer(1'b1, 1'b1, 16'h0000, 16'h8000, 16'd0, 8'h00, 8'h00, 8'h00, 0, 0, 1'b1);
        // delayed read ack, immediate write ack
        run_xfer(1'b0, 1'b0, 16'h1234, 16'h5678, 16'd7, 8'h00, 8'h41, 8'hA5, 4, 0, 1'b0);
        // undocumented-flag example (also valid for the default build)
        run_xfer(1'b0, 1'b0, 16'h0100, 16'h0200, 16'd5, 8'h10, 8'h00, 8'h22, 0, 0, 1'b0);

        reset_mid_write();
        run_xfer(1'b0, 1'b1, 16'h4000, 16'h5000, 16'd9, 8'h00, 8'hC1, 8'h77, 1, 3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_xfer(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                     ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_block_xfer_engine.md
Name: z80_block_xfer_engine

Overview:
- Sequential execution unit for the Z80 block-transfer family LDI, LDD, LDIR and LDDR.
- Mode inputs select address direction and repeat.
- Performs one transfer iteration per start: memory read, memory write, extended cycles, and the optional repeat cycles.
- Issues read/write bus handshakes, returns updated HL/DE/BC/F, and tells the sequencer whether IP rewinds, so interrupts can be sampled between iterations.
- Sits between the core's instruction sequencer and its memory bus interface.

Parameters:
- ADDR_W, 16: width of the HL/DE pointers and bus addresses.
- CNT_W, 16: width of the BC counter.
- DATA_W, 8: bus data width.
- REP_CYCLES, 5: length of the repeat internal cycle in clocks.
- EXT_CYCLES, 2: length of the extended cycles in clocks.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous reset, active-high
- start  in  1  begin one iteration; sampled only when busy=0
- mode_dec  in  1  1 = decrement HL/DE (LDD/LDDR); 0 = increment (LDI/LDIR)
- mode_rep  in  1  1 = repeating form (LDIR/LDDR)
- hl_in  in  ADDR_W  source pointer
- de_in  in  ADDR_W  destination pointer
- bc_in  in  CNT_W  byte counter
- a_in  in  8  accumulator; used only by the optional feature
- f_in  in  8  flags in
- bus_rd_req  out  1  read request
- bus_raddr  out  ADDR_W  read address
- bus_rdata  in  DATA_W  read data
- bus_rd_ack  in  1  read complete
- bus_wr_req  out  1  write request
- bus_waddr  out  ADDR_W  write address
- bus_wdata  out  DATA_W  write data
- bus_wr_ack  in  1  write complete
- hl_out  out  ADDR_W  updated HL
- de_out  out  ADDR_W  updated DE
- bc_out  out  CNT_W  updated BC
- f_out  out  8  updated flags
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse; all outputs valid
- rewind  out  1  with done: IP must not advance past the instruction

Behaviour:
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - All outputs go to 0; bus requests deassert immediately.
  - Reset mid-iteration abandons the iteration: no done, no register update.
- States: IDLE, READ, WRITE, EXT, REP, DONE.
- IDLE:
  - start=1 latches mode, hl_in, de_in, bc_in, a_in and f_in.
  - Next state is READ; busy=1 from the next cycle.
- READ:
  - bus_rd_req=1 and bus_raddr=latched HL until ack is sampled.
  - bus_rdata is latched in the ack cycle.
  - Exit to WRITE when ack has been seen and at least 3 cycles have been spent in READ.
  - Ack may arrive in the first cycle. Ack while req=0 is ignored.
  - Zero-wait READ takes exactly 3 cycles.
- WRITE:
  - Same rules as READ, using bus_wr_req, bus_waddr = latched DE and bus_wdata = latched byte.
  - Minimum 3 cycles.
- EXT: EXT_CYCLES cycles, no bus activity.
- Count and repeat decision (computed during EXT):
  - bc_new = bc - 1, modulo 2^CNT_W. bc=0 wraps to all-ones and gives PV=1.
  - rep_go = mode_rep and bc_new != 0.
- After EXT:
  - rep_go=1: go to REP for REP_CYCLES cycles, then DONE.
  - rep_go=0: go straight to DONE.
- DONE (one cycle): done=1, busy=0, rewind=rep_go. Next state is IDLE.
- Pointer update:
  - HL and DE each step ±1 modulo 2^ADDR_W; wrap 0x0000→0xFFFF and 0xFFFF→0x0000 is legal.
  - hl_out, de_out, bc_out and f_out update in the DONE cycle and hold until the next DONE or reset.
- Flags:
  - H(bit4)=0, N(bit1)=0, PV(bit2) = (bc_new != 0).
  - S, Z and C are preserved.
  - Bits 3 and 5 follow the optional feature.
- start while busy is ignored.
- start in the DONE cycle is ignored.
- Zero-wait latency from start sample edge:
  - Non-repeat: done at cycle 9.
  - Repeat: done at cycle 9 + REP_CYCLES.
  - These match the 8 and 13 non-fetch T-states.

Optional Feature:
- Macro: Z80_BLOCK_XFER_UNDOC_XY_EN.
- Defined:
  - n = a_in + transferred byte, modulo 256.
  - f_out bit3 = n[3]; f_out bit5 = n[1].
- Undefined:
  - Bits 3 and 5 are copied from f_in.
  - a_in is unused.

Test Plan:
- LDD, HL=0x1000, DE=0x2000, BC=3, F=0xFF, mem[0x1000]=0x5A, zero wait → write 0x5A to 0x2000; HL=0x0FFF, DE=0x1FFF, BC=2, F=0xED, rewind=0; done at cycle 9.
- LDIR, HL=0xFFFF, DE=0x0000, BC=1, F=0x00 → HL=0x0000, DE=0x0001, BC=0, F=0x00, rewind=0, no REP cycles.
- LDDR, BC=0, F=0x00 → BC=0xFFFF, PV set (F=0x04), rewind=1; done at cycle 14.
- rd_ack delayed 4 cycles, wr_ack on the first cycle → READ lasts 5 cycles, WRITE lasts 3; rdata is captured on the ack cycle; done at cycle 11.
- Reset asserted mid-WRITE → bus_wr_req drops without waiting for a clock; no done; outputs 0; a new start then completes normally.
- With UNDOC_XY_EN: A=0x10, byte=0x22, F=0x00, LDI, BC=5 → n=0x32; F=0x04 with bit3=0 and bit5=1, i.e. 0x24.
